// File: rtl/adder_serial_nbit_if.sv
// ----------------------------------------------------------------------------
// adder_serial_nbit_if
//
// Purpose:
//    Bundles the request / result handshake of the bit-serial adder so the
//    producer/consumer side and the adder itself share one set of signals.
//
// Parameters:
//    DATA_WIDTH  operand and sum width in bits (2..32)
//
// Signals:
//    start_in    request to add a_in and b_in (producer -> adder)
//    a_in        addend A, unsigned           (producer -> adder)
//    b_in        addend B, unsigned           (producer -> adder)
//    ready_in    consumer takes the result     (consumer -> adder)
//    busy_out    operation running or result pending (adder -> user)
//    sum_out     (a+b) mod 2^DATA_WIDTH        (adder -> user)
//    carry_out   bit DATA_WIDTH of a+b         (adder -> user)
//    valid_out   sum_out/carry_out hold a new result (adder -> user)
//
// Modports:
//    master  the side that issues requests and consumes results
//    slave   the adder
// ----------------------------------------------------------------------------
interface adder_serial_nbit_if #(
   parameter int DATA_WIDTH = 4
);

   logic                  start_in;
   logic [DATA_WIDTH-1:0] a_in;
   logic [DATA_WIDTH-1:0] b_in;
   logic                  ready_in;
   logic                  busy_out;
   logic [DATA_WIDTH-1:0] sum_out;
   logic                  carry_out;
   logic                  valid_out;

   modport master (
      output start_in,
      output a_in,
      output b_in,
      output ready_in,
      input  busy_out,
      input  sum_out,
      input  carry_out,
      input  valid_out
   );

   modport slave (
      input  start_in,
      input  a_in,
      input  b_in,
      input  ready_in,
      output busy_out,
      output sum_out,
      output carry_out,
      output valid_out
   );

endinterface

// File: rtl/adder_serial_nbit.sv
// ----------------------------------------------------------------------------
// adder_serial_nbit
//
// Purpose:
//    Bit-serial unsigned adder. A request is accepted in IDLE, the captured
//    operands are added one bit per clock (LSB first) through a single full
//    adder, and the DATA_WIDTH-bit sum plus carry-out is presented with a
//    valid/ready handshake. The result appears a fixed DATA_WIDTH+1 cycles
//    after the accept edge and stays on the outputs until the next result.
//
// Parameters:
//    DATA_WIDTH  operand and sum width in bits (2..32)
//
// Ports:
//    clk_in      single clock, everything updates on the rising edge
//    rst_in      synchronous active-high reset; also forces all outputs to 0
//    bus         adder_serial_nbit_if.slave carrying start/operands/ready
//                in and busy/sum/carry/valid out
// ----------------------------------------------------------------------------
module adder_serial_nbit #(
   parameter int DATA_WIDTH = 4
) (
   input logic               clk_in,
   input logic               rst_in,
   adder_serial_nbit_if.slave bus
);

   // Counter must reach DATA_WIDTH itself: values 0..DATA_WIDTH-1 mark the
   // bit being added, DATA_WIDTH marks the commit cycle.
   localparam int CNT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic [DATA_WIDTH-1:0] a_q;
   logic [DATA_WIDTH-1:0] a_d;
   logic [DATA_WIDTH-1:0] b_q;
   logic [DATA_WIDTH-1:0] b_d;
   logic [DATA_WIDTH-1:0] acc_q;
   logic [DATA_WIDTH-1:0] acc_d;
   logic [DATA_WIDTH-1:0] sum_q;
   logic [DATA_WIDTH-1:0] sum_d;
   logic                  carry_q;
   logic                  carry_d;
   logic                  cout_q;
   logic                  cout_d;
   logic [CNT_W-1:0]      cnt_q;
   logic [CNT_W-1:0]      cnt_d;
   logic                  bit_sum;
   logic                  bit_carry;

   // One full adder serves every bit position. The operand registers shift
   // right so the bit being added is always in position 0.
   always_comb begin
      bit_sum   = a_q[0] ^ b_q[0] ^ carry_q;
      bit_carry = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
   end

   // Next-state and datapath control. Every register defaults to holding its
   // value, so only the cases that change something are spelled out.
   // In SHIFT the sum bits enter the accumulator at the MSB and walk down, so
   // after DATA_WIDTH bits the accumulator holds the sum in natural order.
   // The extra SHIFT cycle with the counter at DATA_WIDTH copies the
   // accumulator and carry into the output registers; this keeps the result
   // registers untouched while an addition is in flight, which is what lets
   // sum_out/carry_out show the previous result outside DONE.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;

      case (state_q)
         IDLE: begin
            if (bus.start_in) begin
               a_d     = bus.a_in;
               b_d     = bus.b_in;
               acc_d   = '0;
               carry_d = 1'b0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            if (cnt_q == CNT_LAST) begin
               sum_d   = acc_q;
               cout_d  = carry_q;
               state_d = DONE;
            end else begin
               a_d     = a_q >> 1;
               b_d     = b_q >> 1;
               acc_d   = {bit_sum, acc_q[DATA_WIDTH-1:1]};
               carry_d = bit_carry;
               cnt_d   = cnt_q + 1'b1;
            end
         end

         DONE: begin
            if (bus.ready_in) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers. Reset returns to IDLE and clears every
   // register, including the result registers, so the outputs read 0 until
   // the first result completes and an aborted operation leaves nothing
   // behind.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs come straight from registers, but are also forced low for the
   // whole time reset is held, not just from the edge after it rises.
   always_comb begin
      bus.busy_out  = (state_q != IDLE) & ~rst_in;
      bus.valid_out = (state_q == DONE) & ~rst_in;
      bus.sum_out   = rst_in ? '0 : sum_q;
      bus.carry_out = cout_q & ~rst_in;
   end

endmodule

// File: tb/tb_adder_serial_nbit.sv
// ----------------------------------------------------------------------------
// tb_adder_serial_nbit
//
// Purpose:
//    Self-checking bench for adder_serial_nbit. A 4-bit instance covers the
//    directed scenarios; a 32-bit instance runs a random regression with
//    random ready_in. Expected sums are pushed to a queue when a request is
//    accepted and popped when the adder presents its result.
// ----------------------------------------------------------------------------
module tb_adder_serial_nbit;

   logic clk = 1'b0;
   logic rst4;
   logic rst32;

   int vectors     = 0;
   int miscompares = 0;

   logic [4:0]  exp4_q[$];
   logic [32:0] exp32_q[$];

   adder_serial_nbit_if #(.DATA_WIDTH(4))  if4 ();
   adder_serial_nbit_if #(.DATA_WIDTH(32)) if32 ();

   adder_serial_nbit #(.DATA_WIDTH(4)) dut4 (
      .clk_in (clk),
      .rst_in (rst4),
      .bus    (if4.slave)
   );

   adder_serial_nbit #(.DATA_WIDTH(32)) dut32 (
      .clk_in (clk),
      .rst_in (rst32),
      .bus    (if32.slave)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Absolute time limit so the run can never hang
   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog timeout got running want finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance one rising edge; inputs are driven and outputs sampled 1 ns later
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset behaviour: outputs zero while held, reset beats start/ready, and a
   // start on the first edge after release is accepted
   task automatic test_reset();
      logic [4:0] e;
      int         k;
      rst4          = 1'b1;
      if4.start_in  = 1'b1;
      if4.a_in      = 4'hF;
      if4.b_in      = 4'hF;
      if4.ready_in  = 1'b1;
      tick();
      tick();
      vectors++;
      if (if4.busy_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_busy got %b want 0", if4.busy_out);
      end
      vectors++;
      if (if4.valid_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_valid got %b want 0", if4.valid_out);
      end
      vectors++;
      if (if4.sum_out !== 4'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_sum got %h want 0", if4.sum_out);
      end
      vectors++;
      if (if4.carry_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_carry got %b want 0", if4.carry_out);
      end

      rst4         = 1'b0;
      if4.a_in     = 4'h6;
      if4.b_in     = 4'h5;
      tick();
      exp4_q.push_back(5'h0B);
      if4.start_in = 1'b0;
      vectors++;
      if (if4.busy_out !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL first_edge_accept got busy=%b want 1", if4.busy_out);
      end
      k = 0;
      while (!if4.valid_out && k < 20) begin
         tick();
         k++;
      end
      e = exp4_q.pop_front();
      vectors++;
      if ({if4.carry_out, if4.sum_out} !== e) begin
         miscompares++;
         $display("[TB] FAIL first_edge_result got %h want %h", {if4.carry_out, if4.sum_out}, e);
      end
      tick();
   endtask

   // Table of operand pairs including both carry extremes; checks latency,
   // result, busy during DONE, release after handshake and result hold in IDLE
   task automatic test_basic_ops();
      logic [7:0] pairs [6] = '{8'h35, 8'hFF, 8'h00, 8'h97, 8'h88, 8'h1E};
      logic [3:0] a;
      logic [3:0] b;
      logic [4:0] e;
      int         k;
      if4.ready_in = 1'b1;
      for (int i = 0; i < 6; i++) begin
         a            = pairs[i][7:4];
         b            = pairs[i][3:0];
         if4.a_in     = a;
         if4.b_in     = b;
         if4.start_in = 1'b1;
         tick();
         exp4_q.push_back({1'b0, a} + {1'b0, b});
         if4.start_in = 1'b0;
         k = 0;
         while (!if4.valid_out && k < 20) begin
            tick();
            k++;
         end
         vectors++;
         if (k !== 5) begin
            miscompares++;
            $display("[TB] FAIL basic_latency[%0d] got %0d want 5", i, k);
         end
         e = exp4_q.pop_front();
         vectors++;
         if ({if4.carry_out, if4.sum_out} !== e) begin
            miscompares++;
            $display("[TB] FAIL basic_result[%0d] got %h want %h", i, {if4.carry_out, if4.sum_out}, e);
         end
         vectors++;
         if (if4.busy_out !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL basic_busy_done[%0d] got %b want 1", i, if4.busy_out);
         end
         tick();
         vectors++;
         if (if4.valid_out !== 1'b0 || if4.busy_out !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic_release[%0d] got valid=%b busy=%b want 0 0", i, if4.valid_out, if4.busy_out);
         end
         vectors++;
         if ({if4.carry_out, if4.sum_out} !== e) begin
            miscompares++;
            $display("[TB] FAIL basic_hold_idle[%0d] got %h want %h", i, {if4.carry_out, if4.sum_out}, e);
         end
      end
   endtask

   // Result held for 10 cycles of ready_in=0 while new start pulses arrive;
   // a start coinciding with the handshake edge must not be accepted
   task automatic test_backpressure();
      logic [4:0] e;
      int         k;
      if4.ready_in = 1'b0;
      if4.a_in     = 4'h6;
      if4.b_in     = 4'hB;
      if4.start_in = 1'b1;
      tick();
      exp4_q.push_back(5'h11);
      if4.start_in = 1'b0;
      k = 0;
      while (!if4.valid_out && k < 20) begin
         tick();
         k++;
      end
      e = exp4_q.pop_front();
      vectors++;
      if ({if4.carry_out, if4.sum_out} !== e) begin
         miscompares++;
         $display("[TB] FAIL bp_result got %h want %h", {if4.carry_out, if4.sum_out}, e);
      end
      for (int i = 0; i < 10; i++) begin
         if4.start_in = 1'b1;
         if4.a_in     = 4'($urandom);
         if4.b_in     = 4'($urandom);
         tick();
         vectors++;
         if (if4.valid_out !== 1'b1 || if4.busy_out !== 1'b1 || {if4.carry_out, if4.sum_out} !== e) begin
            miscompares++;
            $display("[TB] FAIL bp_hold[%0d] got valid=%b busy=%b res=%h want 1 1 %h", i, if4.valid_out, if4.busy_out, {if4.carry_out, if4.sum_out}, e);
         end
      end
      if4.ready_in = 1'b1;
      if4.start_in = 1'b1;
      tick();
      if4.start_in = 1'b0;
      vectors++;
      if (if4.valid_out !== 1'b0 || if4.busy_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL bp_start_at_handshake got valid=%b busy=%b want 0 0", if4.valid_out, if4.busy_out);
      end
      tick();
      vectors++;
      if (if4.busy_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL bp_idle_after got busy=%b want 0", if4.busy_out);
      end
   endtask

   // Operands scrambled every cycle after the accept edge
   task automatic test_operand_change();
      logic [4:0] e;
      int         k;
      if4.ready_in = 1'b1;
      if4.a_in     = 4'hA;
      if4.b_in     = 4'h7;
      if4.start_in = 1'b1;
      tick();
      exp4_q.push_back(5'h11);
      if4.start_in = 1'b0;
      k = 0;
      while (!if4.valid_out && k < 20) begin
         if4.a_in = 4'($urandom);
         if4.b_in = 4'($urandom);
         tick();
         k++;
      end
      e = exp4_q.pop_front();
      vectors++;
      if ({if4.carry_out, if4.sum_out} !== e) begin
         miscompares++;
         $display("[TB] FAIL opchange_result got %h want %h", {if4.carry_out, if4.sum_out}, e);
      end
      tick();
   endtask

   // Reset two bits into an addition: all outputs drop, no result follows,
   // and a fresh request then completes with its own operands
   task automatic test_reset_mid_shift();
      logic [4:0] e;
      int         k;
      logic       seen;
      if4.ready_in = 1'b1;
      if4.a_in     = 4'hC;
      if4.b_in     = 4'h6;
      if4.start_in = 1'b1;
      tick();
      if4.start_in = 1'b0;
      tick();
      tick();
      rst4 = 1'b1;
      #1;
      vectors++;
      if (if4.busy_out !== 1'b0 || if4.valid_out !== 1'b0 || if4.sum_out !== 4'h0 || if4.carry_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL midreset_hold got busy=%b valid=%b sum=%h carry=%b want 0 0 0 0", if4.busy_out, if4.valid_out, if4.sum_out, if4.carry_out);
      end
      tick();
      rst4 = 1'b0;
      #1;
      vectors++;
      if (if4.busy_out !== 1'b0 || if4.valid_out !== 1'b0 || if4.sum_out !== 4'h0 || if4.carry_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL midreset_after got busy=%b valid=%b sum=%h carry=%b want 0 0 0 0", if4.busy_out, if4.valid_out, if4.sum_out, if4.carry_out);
      end
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (if4.valid_out) seen = 1'b1;
      end
      vectors++;
      if (seen !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL midreset_no_valid got %b want 0", seen);
      end
      if4.a_in     = 4'h5;
      if4.b_in     = 4'h4;
      if4.start_in = 1'b1;
      tick();
      exp4_q.push_back(5'h09);
      if4.start_in = 1'b0;
      k = 0;
      while (!if4.valid_out && k < 20) begin
         tick();
         k++;
      end
      e = exp4_q.pop_front();
      vectors++;
      if ({if4.carry_out, if4.sum_out} !== e || k !== 5) begin
         miscompares++;
         $display("[TB] FAIL midreset_new_op got %h lat %0d want %h lat 5", {if4.carry_out, if4.sum_out}, k, e);
      end
      tick();
   endtask

   // Random 32-bit regression with random ready_in, including while busy
   task automatic test_random32();
      logic [31:0] a;
      logic [31:0] b;
      logic [32:0] e;
      logic [32:0] held;
      logic        r;
      int          k;
      int          n;
      rst32 = 1'b1;
      tick();
      tick();
      rst32 = 1'b0;
      for (int op = 0; op < 400; op++) begin
         a             = $urandom;
         b             = $urandom;
         if (op == 0) begin
            a = 32'hFFFF_FFFF;
            b = 32'hFFFF_FFFF;
         end
         if32.a_in     = a;
         if32.b_in     = b;
         if32.start_in = 1'b1;
         tick();
         exp32_q.push_back({1'b0, a} + {1'b0, b});
         if32.start_in = 1'b0;
         k = 0;
         while (!if32.valid_out && k < 60) begin
            if32.ready_in = 1'($urandom);
            tick();
            k++;
         end
         vectors++;
         if (k !== 33) begin
            miscompares++;
            $display("[TB] FAIL rand_latency[%0d] got %0d want 33", op, k);
         end
         e = exp32_q.pop_front();
         vectors++;
         if ({if32.carry_out, if32.sum_out} !== e) begin
            miscompares++;
            $display("[TB] FAIL rand_result[%0d] got %h want %h", op, {if32.carry_out, if32.sum_out}, e);
         end
         held = {if32.carry_out, if32.sum_out};
         n = 0;
         do begin
            r             = 1'($urandom);
            if32.ready_in = r;
            tick();
            n++;
            if (!r && (if32.valid_out !== 1'b1 || {if32.carry_out, if32.sum_out} !== held)) begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL rand_hold[%0d] got valid=%b res=%h want 1 %h", op, if32.valid_out, {if32.carry_out, if32.sum_out}, held);
            end
         end while (!r && n < 50);
         vectors++;
         if (if32.valid_out !== 1'b0 || if32.busy_out !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rand_release[%0d] got valid=%b busy=%b want 0 0", op, if32.valid_out, if32.busy_out);
         end
      end
   endtask

   // Test sequence
   initial begin
      rst4          = 1'b1;
      rst32         = 1'b1;
      if4.start_in  = 1'b0;
      if4.a_in      = '0;
      if4.b_in      = '0;
      if4.ready_in  = 1'b0;
      if32.start_in = 1'b0;
      if32.a_in     = '0;
      if32.b_in     = '0;
      if32.ready_in = 1'b0;
      test_reset();
      test_basic_ops();
      test_backpressure();
      test_operand_change();
      test_reset_mid_shift();
      test_random32();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/adder_serial_nbit.md
ADDER_SERIAL_NBIT -- requirements
Module: adder_serial_nbit

Interface
REQ-001 Parameter: DATA_WIDTH, default 4, operand and sum width in bits, legal range 2..32.
REQ-002 clk_in  input  1  single clock; all state updates on rising edge.
REQ-003 rst_in  input  1  synchronous, active-high reset, sampled on rising edge of clk_in.
REQ-004 start_in  input  1  request to add the operands on a_in and b_in.
REQ-005 a_in  input  DATA_WIDTH  addend A, unsigned.
REQ-006 b_in  input  DATA_WIDTH  addend B, unsigned.
REQ-007 ready_in  input  1  consumer accepts the result this cycle.
REQ-008 busy_out  output  1  high while an operation is in progress or a result is pending; low means start_in will be accepted.
REQ-009 sum_out  output  DATA_WIDTH  result sum, (a+b) mod 2^DATA_WIDTH.
REQ-010 carry_out  output  1  carry out of the MSB, bit DATA_WIDTH of a+b.
REQ-011 valid_out  output  1  sum_out/carry_out hold a new result.

Function
REQ-012 The block SHALL implement the states IDLE, SHIFT and DONE.
REQ-013 In IDLE with start_in=1 at edge t, the block SHALL capture a_in and b_in, clear the carry register and the bit counter, and enter SHIFT; busy_out SHALL be 1 from t+1.
REQ-014 In IDLE with start_in=0, the block SHALL remain in IDLE with busy_out=0 and valid_out=0.
REQ-015 In SHIFT, the block SHALL process one bit per cycle, LSB first, with a full-adder: sum bit = a^b^c, next c = majority(a,b,c).
REQ-016 The block SHALL hold SHIFT for exactly DATA_WIDTH cycles (edges t+1 .. t+DATA_WIDTH), then enter DONE.
REQ-017 valid_out SHALL rise at t+DATA_WIDTH+1, giving a fixed latency of DATA_WIDTH+1 cycles from the accept edge to valid_out.
REQ-018 In DONE, sum_out and carry_out SHALL equal the full-width result of the captured operands and SHALL stay stable while valid_out=1.
REQ-019 In DONE with ready_in=1, the handshake SHALL complete on that edge; the next state SHALL be IDLE, with valid_out=0 and busy_out=0 on the following cycle.
REQ-020 In DONE with ready_in=0, the block SHALL hold DONE indefinitely with its outputs unchanged.
REQ-021 start_in SHALL be ignored in SHIFT and DONE; a_in/b_in changes after the accept edge SHALL NOT affect the result.
REQ-022 start_in in the same cycle as a DONE handshake SHALL be ignored; the earliest new accept is the first IDLE cycle.
REQ-023 sum_out/carry_out SHALL hold the last completed result outside DONE and SHALL be 0 before the first result.
REQ-024 ready_in SHALL be ignored outside DONE.
REQ-025 The carry chain SHALL be exact for all operand values, including a=b=2^DATA_WIDTH-1 and a=b=0.

Reset
REQ-026 With rst_in=1 at an edge, the block SHALL go to IDLE and clear the operand, carry and counter registers.
REQ-027 While rst_in=1, all outputs SHALL be 0: busy_out, valid_out, sum_out and carry_out.
REQ-028 rst_in SHALL take priority over start_in and ready_in.
REQ-029 Reset asserted in SHIFT or DONE SHALL abort the operation; no valid_out SHALL follow for the aborted operation.
REQ-030 After rst_in deasserts, a start_in on the first clock edge SHALL be accepted.

Verification
REQ-031 DATA_WIDTH=4, a=0011, b=0101, ready_in=1 -> valid_out at cycle 5 after accept, sum=1000, carry=0, busy_out=0 one cycle later.
REQ-032 DATA_WIDTH=4, a=1111, b=1111 -> sum=1110, carry=1; a=0, b=0 -> sum=0000, carry=0.
REQ-033 Backpressure: ready_in=0 for 10 cycles after valid_out -> outputs frozen, start_in pulses with new operands ignored; ready_in=1 -> IDLE on the next cycle.
REQ-034 Reset mid-SHIFT (bit 2 of 4) -> next cycle all outputs 0; no valid_out appears; a new start_in gives the correct result for its own operands.
REQ-035 Operands change on a_in/b_in every cycle during SHIFT -> result matches the operands captured at accept.
REQ-036 Random regression, DATA_WIDTH=8 and 32, 10k ops with random ready_in -> {carry_out,sum_out} == a+b for every handshake, latency exactly DATA_WIDTH+1.
